// File: rtl/slot_arbiter.sv
// slot_arbiter: round-robin arbiter that hands out a single resource in
// time slots. Each slot ends on release, on a holder request drop, or when
// the per-grant slice length expires; every slot end is followed by one
// idle GAP cycle before the next arbitration.
module slot_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic                     i_release,
  input  logic [CW-1:0]            i_slice,
  output logic [NREQ-1:0]          o_gnt,
  output logic [$clog2(NREQ)-1:0]  o_gnt_id,
  output logic                     o_busy,
  output logic [CW-1:0]            o_count,
  output logic                     o_timeout
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned SW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;

  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [CW-1:0]   slice_q;
  logic [CW-1:0]   slice_d;

  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   gnt_id_d;
  logic            busy_d;
  logic [CW-1:0]   count_d;
  logic            timeout_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [SW-1:0]   sum;
  logic [IW-1:0]   idx;

  logic            holder_req;
  logic            expired;
  logic            slot_end;
  logic [CW-1:0]   count_inc;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Rotating search: first set request at or above ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = sum[IW-1:0];
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Slot termination conditions for the current holder
  always_comb begin
    holder_req = i_req[o_gnt_id];
    expired    = (slice_q != '0) && (o_count == slice_q);
    slot_end   = !holder_req || i_release || expired;
    count_inc  = o_count + CW'(1);
    if (count_inc == '0) begin
      count_inc = CW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAP: state_d = found ? S_GRANT : S_IDLE;
      S_GRANT:       state_d = slot_end ? S_GAP : S_GRANT;
      default:       state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and slot bookkeeping
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    busy_d    = 1'b0;
    count_d   = '0;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    slice_d   = slice_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (found) begin
          gnt_d    = NREQ'(1) << pick;
          gnt_id_d = pick;
          busy_d   = 1'b1;
          count_d  = CW'(1);
          slice_d  = i_slice;
          ptr_d    = (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);
        end
      end
      S_GRANT: begin
        if (slot_end) begin
          // Timeout only when expiry is the sole reason the slot ended
          timeout_d = expired && holder_req && !i_release;
        end else begin
          gnt_d    = o_gnt;
          gnt_id_d = o_gnt_id;
          busy_d   = 1'b1;
          count_d  = count_inc;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt     <= '0;
      o_gnt_id  <= '0;
      o_busy    <= 1'b0;
      o_count   <= '0;
      o_timeout <= 1'b0;
      ptr_q     <= '0;
      slice_q   <= '0;
    end else begin
      o_gnt     <= gnt_d;
      o_gnt_id  <= gnt_id_d;
      o_busy    <= busy_d;
      o_count   <= count_d;
      o_timeout <= timeout_d;
      ptr_q     <= ptr_d;
      slice_q   <= slice_d;
    end
  end

endmodule

// File: tb/tb_slot_arbiter.sv
// Self-checking bench for slot_arbiter: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_slot_arbiter;

  localparam int N  = 4;
  localparam int CW = 6;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_req;
  logic           i_release;
  logic [CW-1:0]  i_slice;
  logic [N-1:0]   o_gnt;
  logic [1:0]     o_gnt_id;
  logic           o_busy;
  logic [CW-1:0]  o_count;
  logic           o_timeout;

  int errors = 0;
  int checks = 0;

  // Behavioural model: who holds the resource, for how long, and where the
  // next search starts. holder < 0 means nobody holds it.
  int m_holder = -1;
  int m_cnt    = 0;
  int m_slice  = 0;
  int m_ptr    = 0;
  bit m_tmo    = 1'b0;

  slot_arbiter #(.NREQ(N), .CW(CW)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_release (i_release),
    .i_slice   (i_slice),
    .o_gnt     (o_gnt),
    .o_gnt_id  (o_gnt_id),
    .o_busy    (o_busy),
    .o_count   (o_count),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the specification's rules, applied to the sampled inputs
  task automatic model_step(input bit rst, input logic [N-1:0] req, input bit rel, input int sl);
    bit exp_hit;
    bit drop;
    m_tmo = 1'b0;
    if (rst) begin
      m_holder = -1;
      m_cnt    = 0;
      m_ptr    = 0;
      m_slice  = 0;
    end else if (m_holder < 0) begin
      m_cnt = 0;
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_ptr + j) % N;
        if (m_holder < 0 && req[k]) begin
          m_holder = k;
          m_cnt    = 1;
          m_slice  = sl;
        end
      end
      if (m_holder >= 0) m_ptr = (m_holder + 1) % N;
    end else begin
      exp_hit = (m_slice != 0) && (m_cnt == m_slice);
      drop    = !req[m_holder];
      if (drop || rel || exp_hit) begin
        m_tmo    = exp_hit && !drop && !rel;
        m_holder = -1;
        m_cnt    = 0;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_cnt == 0) m_cnt = 1;
      end
    end
  endtask

  // Compare every DUT output with the model, plus structural invariants
  task automatic compare_all();
    int exp_gnt;
    bit inv_ok;
    exp_gnt = (m_holder < 0) ? 0 : (1 << m_holder);
    check("gnt",     longint'(o_gnt),     longint'(exp_gnt));
    check("gnt_id",  longint'(o_gnt_id),  longint'((m_holder < 0) ? 0 : m_holder));
    check("busy",    longint'(o_busy),    longint'(m_holder >= 0));
    check("count",   longint'(o_count),   longint'(m_cnt));
    check("timeout", longint'(o_timeout), longint'(m_tmo));
    inv_ok = $onehot0(o_gnt) && (o_busy == (|o_gnt)) && ((o_count != '0) == o_busy)
             && (!o_timeout || (o_gnt == '0));
    check("invariants", longint'(inv_ok), 64'd1);
  endtask

  task automatic cycle(input bit rst, input logic [N-1:0] req, input bit rel, input int sl);
    i_rst     = rst;
    i_req     = req;
    i_release = rel;
    i_slice   = CW'(sl);
    @(posedge i_clk);
    model_step(rst, req, rel, sl);
    #1;
    compare_all();
  endtask

  int exp_tbl [14] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1};

  initial begin
    // Single slot with slice expiry
    cycle(1'b1, 4'b0000, 1'b0, 0);
    check("rst_gnt", longint'(o_gnt), 0);
    check("rst_count", longint'(o_count), 0);
    cycle(1'b0, 4'b0100, 1'b0, 3);
    check("t1_gnt", longint'(o_gnt), 4);
    check("t1_id", longint'(o_gnt_id), 2);
    check("t1_c1", longint'(o_count), 1);
    cycle(1'b0, 4'b0100, 1'b0, 7);
    check("t1_c2", longint'(o_count), 2);
    cycle(1'b0, 4'b0100, 1'b0, 7);
    check("t1_c3", longint'(o_count), 3);
    cycle(1'b0, 4'b0100, 1'b0, 7);
    check("t1_gap_tmo", longint'(o_timeout), 1);
    check("t1_gap_gnt", longint'(o_gnt), 0);

    // Full rotation with all requesters
    cycle(1'b1, 4'b0000, 1'b0, 0);
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 4'b1111, 1'b0, 2);
      check("t2_rot", longint'(o_gnt), longint'(exp_tbl[k]));
    end

    // Release with unlimited slice, then release coinciding with expiry
    cycle(1'b1, 4'b0000, 1'b0, 0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 4'b0010, 1'b0, 0);
    check("t3_c5", longint'(o_count), 5);
    cycle(1'b0, 4'b0010, 1'b1, 0);
    check("t3_rel_tmo", longint'(o_timeout), 0);
    check("t3_rel_gnt", longint'(o_gnt), 0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0010, 1'b0, 3);
    check("t3_c3", longint'(o_count), 3);
    cycle(1'b0, 4'b0010, 1'b1, 3);
    check("t3_coinc_tmo", longint'(o_timeout), 0);

    // Holder drops request; pointer advances past it
    cycle(1'b1, 4'b0000, 1'b0, 0);
    cycle(1'b0, 4'b0010, 1'b0, 10);
    cycle(1'b0, 4'b0010, 1'b0, 10);
    check("t4_c2", longint'(o_count), 2);
    cycle(1'b0, 4'b0000, 1'b0, 10);
    check("t4_drop_tmo", longint'(o_timeout), 0);
    cycle(1'b0, 4'b0011, 1'b0, 10);
    check("t4_next", longint'(o_gnt), 1);

    // Mid-slot reset, then search from pointer 0
    cycle(1'b1, 4'b0000, 1'b0, 0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0100, 1'b0, 0);
    check("t5_c4", longint'(o_count), 4);
    cycle(1'b1, 4'b0100, 1'b0, 0);
    check("t5_rst_busy", longint'(o_busy), 0);
    cycle(1'b0, 4'b1000, 1'b0, 0);
    check("t5_id", longint'(o_gnt_id), 3);

    // Unlimited slice wraps from all-ones back to 1
    cycle(1'b1, 4'b0000, 1'b0, 0);
    for (int k = 0; k < 64; k++) cycle(1'b0, 4'b0001, 1'b0, 0);
    check("t6_wrap", longint'(o_count), 1);
    cycle(1'b0, 4'b0001, 1'b0, 0);
    check("t6_wrap2", longint'(o_count), 2);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] rq;
      bit rl;
      bit rs;
      int sl;
      rq = N'($urandom);
      if ($urandom_range(0, 3) == 0) rq = '0;
      rl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 199) == 0);
      sl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      if ($urandom_range(0, 4) != 0 && m_holder >= 0) rq[m_holder] = 1'b1;
      cycle(rs, rq, rl, sl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slot_arbiter.md
SLOT_ARBITER -- requirements
Module: slot_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the slot counter (2..16).
REQ-002 Parameter CW, default 16, width of slot length and slot cycle counter.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  NREQ  per-requester request level; bit k high = requester k wants the resource.
REQ-006 i_release  input  1  current holder finished; ends the slot at this edge.
REQ-007 i_slice  input  CW  slot length in cycles; 0 = unlimited.
REQ-008 o_gnt  output  NREQ  registered one-hot grant; all-zero when no holder.
REQ-009 o_gnt_id  output  $clog2(NREQ)  index of current holder; 0 when o_gnt is zero.
REQ-010 o_busy  output  1  high exactly when o_gnt is non-zero.
REQ-011 o_count  output  CW  cycles elapsed in current slot, 1 on first grant cycle; 0 when no holder.
REQ-012 o_timeout  output  1  one-cycle pulse when a slot ended by slice expiry.

Function
REQ-013 The block SHALL implement states IDLE, GRANT, GAP; all outputs registered.
REQ-014 In IDLE or GAP, at an edge with i_req != 0, the block SHALL enter GRANT, select the first set i_req bit searching upward from pointer ptr modulo NREQ, set o_gnt/o_gnt_id to it, set o_count = 1, latch i_slice into slice_q.
REQ-015 On each grant, ptr SHALL be set to (granted index + 1) mod NREQ.
REQ-016 In IDLE or GAP with i_req == 0, the block SHALL go to (remain in) IDLE with o_gnt = 0, o_count = 0.
REQ-017 In GRANT, the slot SHALL end at an edge where i_req[holder] == 0, or i_release == 1, or (slice_q != 0 and o_count == slice_q).
REQ-018 On slot end the block SHALL enter GAP: o_gnt = 0, o_gnt_id = 0, o_count = 0; GAP lasts exactly one cycle.
REQ-019 o_timeout SHALL be 1 for the GAP cycle only when the slot ended solely by slice expiry; if i_release or holder request drop coincides with expiry, o_timeout SHALL be 0.
REQ-020 Otherwise in GRANT, o_count SHALL increment by 1 per cycle; with slice_q == 0 it SHALL wrap from all-ones to 1, never 0.
REQ-021 Changes of i_slice during GRANT SHALL have no effect until the next grant.
REQ-022 Requests of non-holders during GRANT SHALL be ignored until GAP; a holder never receives two consecutive slots while another requester is pending.
REQ-023 Grant latency SHALL be exactly 1 cycle from request sampled in IDLE/GAP; holder with slice S holds o_gnt for exactly S cycles if not released.

Reset
REQ-024 At an edge with i_rst = 1 the block SHALL enter IDLE, ptr = 0, o_gnt = 0, o_gnt_id = 0, o_busy = 0, o_count = 0, o_timeout = 0, regardless of state (including mid-slot).
REQ-025 Power-up (initial) values SHALL equal reset values.
REQ-026 Edge after i_rst deasserts SHALL be treated as IDLE arbitration (grant possible).

Verification
REQ-027 Reset, i_req=4'b0100, i_slice=3 -> next cycle o_gnt=0100, o_gnt_id=2, o_count 1,2,3 over three cycles, then GAP with o_timeout=1, o_count=0.
REQ-028 i_req=4'b1111 held, i_slice=2, from ptr 0 -> grants 0,1,2,3,0 each 2 cycles, separated by one zero-grant GAP cycle.
REQ-029 Holder 1, slice 0, i_release at o_count=5 -> GAP next cycle, o_timeout=0; i_release coinciding with o_count==slice_q -> o_timeout=0.
REQ-030 Holder drops i_req at o_count=2, slice 10 -> GAP next cycle, ptr advanced, o_timeout=0.
REQ-031 i_rst asserted at o_count=4 of a slot -> next cycle all outputs 0, state IDLE; with i_req=4'b1000 after release, grant goes to 3 (search from ptr 0).
REQ-032 Formal/assertions: o_gnt one-hot or zero; o_busy == |o_gnt; o_count != 0 iff o_busy; o_timeout implies o_gnt == 0.
